// File: rtl/mfp_usart_tx.sv
// mfp_usart_tx: MFP USART serial transmitter driven by the timer D tick.
module mfp_usart_tx #(
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic       baud_tick,
  input  logic       div16,
  input  logic [1:0] char_len,
  input  logic [1:0] stop_mode,
  input  logic       parity_en,
  input  logic       parity_even,
  input  logic       tx_enable,
  input  logic       break_req,
  input  logic [7:0] data_in,
  input  logic       data_we,
  output logic       buf_empty,
  output logic       underrun,
  output logic       tx_end,
  output logic       busy,
  output logic       txd
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  state_t     r_state;
  logic [7:0] r_hold, r_shift;
  logic       r_buf_empty, r_underrun, r_busy, r_txd, r_brk, r_par, r_par_en;
  logic [5:0] r_cnt, r_bit_len, r_stop_len;
  logic [2:0] r_left, r_nb_m1;
  logic [7:0] w_mask;
  logic [5:0] w_len, w_stop_len;
  logic       w_start_ok, w_bit_end, w_load;
  assign w_mask     = 8'hFF >> char_len;
  assign w_start_ok = tx_enable & ~r_buf_empty & (stop_mode != 2'b00) & ~break_req;
  assign w_len      = (r_state == S_STOP) ? r_stop_len : r_bit_len;
  assign w_bit_end  = baud_tick & (r_cnt + 6'd1 == w_len);
  assign w_stop_len = div16 ? (stop_mode == 2'b01 ? 6'd16 : stop_mode == 2'b10 ? 6'd24 : 6'd32)
                            : (stop_mode == 2'b01 ? 6'd1 : 6'd2);
  // r_brk holds off a new frame for one cycle so the line shows mark after a break
  assign w_load = w_start_ok & ((r_state == S_IDLE & ~r_brk) | (r_state == S_STOP & w_bit_end));
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_hold      <= 8'h00;
      r_shift     <= 8'h00;
      r_buf_empty <= 1'b1;
      r_underrun  <= 1'b0;
      r_busy      <= 1'b0;
      r_txd       <= IDLE_LEVEL;
      r_brk       <= 1'b0;
      r_par       <= 1'b0;
      r_par_en    <= 1'b0;
      r_cnt       <= 6'd0;
      r_bit_len   <= 6'd1;
      r_stop_len  <= 6'd1;
      r_left      <= 3'd0;
      r_nb_m1     <= 3'd7;
    end else if (clk_en) begin
      if (data_we & r_buf_empty) begin
        r_hold      <= data_in;
        r_buf_empty <= 1'b0;
      end
      if (data_we) r_underrun <= 1'b0;
      if (w_load) begin
        r_shift     <= r_hold & w_mask;
        r_par       <= ^(r_hold & w_mask) ^ ~parity_even;
        r_par_en    <= parity_en;
        r_nb_m1     <= 3'd7 - {1'b0, char_len};
        r_bit_len   <= div16 ? 6'd16 : 6'd1;
        r_stop_len  <= w_stop_len;
        r_buf_empty <= 1'b1;
        r_cnt       <= 6'd0;
        r_state     <= S_START;
        r_busy      <= 1'b1;
        r_txd       <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_txd <= break_req ? 1'b0 : IDLE_LEVEL;
            r_brk <= break_req;
          end
          default: begin
            if (baud_tick) r_cnt <= w_bit_end ? 6'd0 : r_cnt + 6'd1;
            if (w_bit_end)
              case (r_state)
                S_START: begin
                  r_state <= S_DATA;
                  r_txd   <= r_shift[0];
                  r_shift <= r_shift >> 1;
                  r_left  <= r_nb_m1;
                end
                S_DATA:
                  if (r_left == 3'd0) begin
                    r_state <= r_par_en ? S_PARITY : S_STOP;
                    r_txd   <= r_par_en ? r_par : 1'b1;
                  end else begin
                    r_txd   <= r_shift[0];
                    r_shift <= r_shift >> 1;
                    r_left  <= r_left - 3'd1;
                  end
                S_PARITY: begin
                  r_state <= S_STOP;
                  r_txd   <= 1'b1;
                end
                default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_txd   <= break_req ? 1'b0 : IDLE_LEVEL;
                  r_brk   <= break_req;
                  if (r_buf_empty) r_underrun <= 1'b1;
                end
              endcase
          end
        endcase
      end
    end
  end
  assign buf_empty = r_buf_empty;
  assign underrun  = r_underrun;
  assign busy      = r_busy;
  assign txd       = r_txd;
  assign tx_end    = ~tx_enable & ~r_busy;
endmodule

// File: tb/tb_mfp_usart_tx.sv
// tb_mfp_usart_tx: scoreboard bench for the MFP serial transmitter.
module tb_mfp_usart_tx;
  logic       clk = 1'b0;
  logic       reset, clk_en, baud_tick, div16, parity_en, parity_even, tx_enable, break_req, data_we;
  logic [1:0] char_len, stop_mode;
  logic [7:0] data_in;
  logic       buf_empty, underrun, tx_end, busy, txd;
  int         total = 0;
  int         bad = 0;
  bit         q[$];
  mfp_usart_tx dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .baud_tick(baud_tick), .div16(div16),
    .char_len(char_len), .stop_mode(stop_mode), .parity_en(parity_en), .parity_even(parity_even),
    .tx_enable(tx_enable), .break_req(break_req), .data_in(data_in), .data_we(data_we),
    .buf_empty(buf_empty), .underrun(underrun), .tx_end(tx_end), .busy(busy), .txd(txd)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic tick();
    baud_tick = 1'b1;
    step();
    baud_tick = 1'b0;
  endtask
  task automatic write(input logic [7:0] d);
    data_in = d;
    data_we = 1'b1;
    step();
    data_we = 1'b0;
  endtask
  task automatic cfg(input logic d16, input logic [1:0] cl, input logic [1:0] sm, input logic pe, input logic pev);
    div16 = d16; char_len = cl; stop_mode = sm; parity_en = pe; parity_even = pev;
  endtask
  // Expected txd level for every tick of one frame.
  function automatic void push_frame(input logic [7:0] d, input int nb, input bit pe, input bit pev, input int bt, input int st);
    int ones = 0;
    repeat (bt) q.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      repeat (bt) q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe) repeat (bt) q.push_back(pev ? bit'(ones % 2) : bit'(1 - ones % 2));
    repeat (st) q.push_back(1'b1);
  endfunction
  task automatic test_reset();
    reset = 1; clk_en = 1; baud_tick = 0; tx_enable = 0; break_req = 0; data_we = 0; data_in = 0;
    cfg(1'b1, 2'b00, 2'b01, 1'b0, 1'b0);
    repeat (3) step();
    reset = 0;
    step();
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd got=%b want=1", txd); end
    total++; if (buf_empty !== 1'b1) begin bad++; $display("FAIL reset_buf_empty got=%b want=1", buf_empty); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b want=0", underrun); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (tx_end !== 1'b1) begin bad++; $display("FAIL reset_tx_end got=%b want=1", tx_end); end
  endtask
  task automatic test_8n1();
    bit e;
    cfg(1'b1, 2'b00, 2'b01, 1'b0, 1'b0);
    tx_enable = 1;
    write(8'h55);
    total++; if (buf_empty !== 1'b0) begin bad++; $display("FAIL 8n1_buf_full got=%b want=0", buf_empty); end
    push_frame(8'h55, 8, 0, 0, 16, 16);
    step();
    total++; if (buf_empty !== 1'b1) begin bad++; $display("FAIL 8n1_buf_empty got=%b want=1", buf_empty); end
    for (int i = 0; i < 160; i++) begin
      e = q.pop_front();
      total++; if (txd !== e || busy !== 1'b1) begin bad++; $display("FAIL 8n1_txd tick=%0d got=%b/%b want=%b/1", i, txd, busy, e); end
      tick();
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL 8n1_busy_end got=%b want=0", busy); end
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL 8n1_underrun got=%b want=1", underrun); end
  endtask
  task automatic test_7e2();
    bit e;
    cfg(1'b0, 2'b01, 2'b11, 1'b1, 1'b1);
    write(8'hC1);
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL 7e2_underrun_clr got=%b want=0", underrun); end
    step();
    cfg(1'b1, 2'b00, 2'b01, 1'b0, 1'b0);
    push_frame(8'hC1, 7, 1, 1, 1, 2);
    for (int i = 0; i < 11; i++) begin
      e = q.pop_front();
      total++; if (txd !== e) begin bad++; $display("FAIL 7e2_txd tick=%0d got=%b want=%b", i, txd, e); end
      tick();
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL 7e2_busy_end got=%b want=0", busy); end
  endtask
  task automatic test_back_to_back();
    bit e;
    cfg(1'b0, 2'b00, 2'b01, 1'b0, 1'b0);
    write(8'hA0);
    step();
    write(8'h0F);
    total++; if (buf_empty !== 1'b0) begin bad++; $display("FAIL b2b_second_held got=%b want=0", buf_empty); end
    push_frame(8'hA0, 8, 0, 0, 1, 1);
    push_frame(8'h0F, 8, 0, 0, 1, 1);
    for (int i = 0; i < 20; i++) begin
      e = q.pop_front();
      total++; if (txd !== e) begin bad++; $display("FAIL b2b_txd tick=%0d got=%b want=%b", i, txd, e); end
      tick();
    end
    total++; if (underrun !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL b2b_end underrun/busy got=%b/%b want=1/0", underrun, busy); end
    tx_enable = 0;
    write(8'h3C);
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL b2b_underrun_clr got=%b want=0", underrun); end
    total++; if (tx_end !== 1'b1 || buf_empty !== 1'b0) begin bad++; $display("FAIL b2b_disabled tx_end/buf_empty got=%b/%b want=1/0", tx_end, buf_empty); end
  endtask
  task automatic test_stop15_drop();
    bit e;
    cfg(1'b1, 2'b00, 2'b10, 1'b0, 1'b0);
    write(8'h99);
    tx_enable = 1;
    step();
    total++; if (busy !== 1'b1 || buf_empty !== 1'b1) begin bad++; $display("FAIL s15_start busy/buf_empty got=%b/%b want=1/1", busy, buf_empty); end
    write(8'h81);
    write(8'h99);
    total++; if (buf_empty !== 1'b0) begin bad++; $display("FAIL s15_hold_full got=%b want=0", buf_empty); end
    push_frame(8'h3C, 8, 0, 0, 16, 24);
    push_frame(8'h81, 8, 0, 0, 16, 24);
    for (int i = 0; i < 336; i++) begin
      e = q.pop_front();
      total++; if (txd !== e) begin bad++; $display("FAIL s15_txd tick=%0d got=%b want=%b", i, txd, e); end
      tick();
    end
    total++; if (busy !== 1'b0 || underrun !== 1'b1) begin bad++; $display("FAIL s15_end busy/underrun got=%b/%b want=0/1", busy, underrun); end
  endtask
  task automatic test_sync_break();
    bit e, prev;
    cfg(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    write(8'h6B);
    repeat (5) tick();
    total++; if (busy !== 1'b0 || buf_empty !== 1'b0 || txd !== 1'b1) begin bad++; $display("FAIL sync_idle busy/buf_empty/txd got=%b/%b/%b want=0/0/1", busy, buf_empty, txd); end
    stop_mode = 2'b01;
    break_req = 1;
    step();
    for (int i = 0; i < 100; i++) begin
      total++; if (txd !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL break_txd tick=%0d txd/busy got=%b/%b want=0/0", i, txd, busy); end
      tick();
    end
    total++; if (buf_empty !== 1'b0) begin bad++; $display("FAIL break_hold got=%b want=0", buf_empty); end
    break_req = 0;
    step();
    total++; if (txd !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL break_release txd/busy got=%b/%b want=1/0", txd, busy); end
    step();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL break_pending_start got=%b want=1", busy); end
    push_frame(8'h6B, 8, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        clk_en = 0;
        prev = txd;
        repeat (3) tick();
        total++; if (txd !== prev) begin bad++; $display("FAIL clk_en_hold got=%b want=%b", txd, prev); end
        clk_en = 1;
      end
      e = q.pop_front();
      total++; if (txd !== e) begin bad++; $display("FAIL brkframe_txd tick=%0d got=%b want=%b", i, txd, e); end
      tick();
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL brkframe_end got=%b want=0", busy); end
  endtask
  task automatic test_reset_mid_frame();
    cfg(1'b1, 2'b00, 2'b01, 1'b0, 1'b0);
    write(8'hF0);
    step();
    write(8'h11);
    repeat (40) tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b want=1", busy); end
    reset = 1;
    tx_enable = 0;
    step();
    reset = 0;
    total++; if (txd !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL midrst txd/busy got=%b/%b want=1/0", txd, busy); end
    total++; if (buf_empty !== 1'b1 || underrun !== 1'b0 || tx_end !== 1'b1) begin bad++; $display("FAIL midrst buf_empty/underrun/tx_end got=%b/%b/%b want=1/0/1", buf_empty, underrun, tx_end); end
    tx_enable = 1;
    repeat (3) tick();
    total++; if (busy !== 1'b0 || txd !== 1'b1) begin bad++; $display("FAIL midrst_discard busy/txd got=%b/%b want=0/1", busy, txd); end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_8n1();
    test_7e2();
    test_back_to_back();
    test_stop15_drop();
    test_sync_break();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
